// File: rtl/ddr3_cmd_responder.sv
// DDR3 device-side responder: decodes the command bus, tracks open rows per bank,
// stores write bursts and returns read bursts on DQ, flagging protocol errors.
module ddr3_cmd_responder #(
    parameter int CL           = 5,
    parameter int CWL          = 5,
    parameter int BURST_LEN    = 4,
    parameter int T_RCD        = 3,
    parameter int ROW_IDX_BITS = 2,
    parameter int COL_IDX_BITS = 5
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        CKE,
    input  logic        CS,
    input  logic        RAS,
    input  logic        CAS,
    input  logic        WE,
    input  logic [2:0]  BA,
    input  logic [14:0] Addr,
    input  logic        LDM,
    input  logic        UDM,
    inout  wire  [15:0] DQ,
    output logic        DQS_rd,
    output logic [7:0]  bank_open,
    output logic [2:0]  last_cmd,
    output logic        burst_active,
    output logic        err_valid,
    output logic [2:0]  err_code
);

    localparam int IDX_W = 3 + ROW_IDX_BITS + COL_IDX_BITS;
    localparam int RCD_W = (T_RCD > 1) ? $clog2(T_RCD) : 1;
    localparam logic [RCD_W-1:0]        RCD_LOAD = RCD_W'(T_RCD - 1);
    localparam logic [7:0]              RD_LAT   = 8'(CL);
    localparam logic [7:0]              WR_LAT   = 8'(CWL);
    localparam logic [7:0]              RD_END   = 8'(CL + BURST_LEN);
    localparam logic [7:0]              WR_END   = 8'(CWL + BURST_LEN);
    localparam logic [COL_IDX_BITS-1:0] BL_MASK  = COL_IDX_BITS'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_REF  = 3'd5,
        CMD_MRS  = 3'd6,
        CMD_ZQCL = 3'd7
    } cmd_e;

    cmd_e                     cmd;
    logic [2:0]               err;
    logic                     is_rw;
    logic                     accept;

    logic [7:0]               bank_open_q, bank_open_d;
    logic [2:0]               last_cmd_q;
    logic [2:0]               err_code_q;
    logic                     err_valid_q;
    logic                     burst_active_q;
    logic                     dq_oe_q;
    logic [RCD_W-1:0]         rcd_q [8];
    logic                     bst_wr_q;
    logic                     bst_ap_q;
    logic [7:0]               cyc_q;

    logic [ROW_IDX_BITS-1:0]  row_q [8];
    logic [2:0]               bst_ba_q;
    logic [ROW_IDX_BITS-1:0]  bst_row_q;
    logic [COL_IDX_BITS-1:0]  bst_col_q;
    logic [15:0]              dq_out_q;
    logic [15:0]              mem [2**IDX_W];

    logic [7:0]               lat;
    logic [7:0]               bend;
    logic [7:0]               beat_num;
    logic                     in_beat;
    logic                     burst_done;
    logic [COL_IDX_BITS-1:0]  beat_col;
    logic [IDX_W-1:0]         beat_idx;
    logic                     unused_addr;

    assign unused_addr = ^Addr;

    always_comb begin
        cmd = CMD_NOP;
        if (!CS) begin
            case ({RAS, CAS, WE})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                3'b110:  cmd = CMD_ZQCL;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Error checks in ascending code order so the lowest applicable code wins.
    always_comb begin
        is_rw = (cmd == CMD_RD) || (cmd == CMD_WR);
        err   = 3'd0;
        if (is_rw && !bank_open_q[BA])                  err = 3'd1;
        else if (cmd == CMD_ACT && bank_open_q[BA])     err = 3'd2;
        else if (is_rw && rcd_q[BA] != '0)              err = 3'd3;
        else if (is_rw && burst_active_q)               err = 3'd4;
        else if (cmd != CMD_NOP && !CKE)                err = 3'd5;
        else if (cmd == CMD_REF && (|bank_open_q))      err = 3'd6;
        accept = (cmd != CMD_NOP) && (err == 3'd0);
    end

    always_comb begin
        lat        = bst_wr_q ? WR_LAT : RD_LAT;
        bend       = bst_wr_q ? WR_END : RD_END;
        in_beat    = burst_active_q && (cyc_q >= lat) && (cyc_q < bend);
        burst_done = burst_active_q && (cyc_q == bend);
        beat_num   = cyc_q - lat;
        // Sequential wrap inside the aligned burst block.
        beat_col   = (bst_col_q & ~BL_MASK) |
                     ((bst_col_q + COL_IDX_BITS'(beat_num)) & BL_MASK);
        beat_idx   = {bst_ba_q, bst_row_q, beat_col};
    end

    always_comb begin
        bank_open_d = bank_open_q;
        if (burst_done && bst_ap_q)
            bank_open_d[bst_ba_q] = 1'b0;
        if (accept && cmd == CMD_PRE) begin
            if (Addr[10]) bank_open_d = '0;
            else          bank_open_d[BA] = 1'b0;
        end
        if (accept && cmd == CMD_ACT)
            bank_open_d[BA] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            bank_open_q    <= '0;
            last_cmd_q     <= CMD_NOP;
            err_code_q     <= 3'd0;
            err_valid_q    <= 1'b0;
            burst_active_q <= 1'b0;
            dq_oe_q        <= 1'b0;
            bst_wr_q       <= 1'b0;
            bst_ap_q       <= 1'b0;
            cyc_q          <= '0;
            for (int b = 0; b < 8; b++) rcd_q[b] <= '0;
        end else begin
            bank_open_q <= bank_open_d;
            err_valid_q <= (err != 3'd0);
            if (err != 3'd0) err_code_q <= err;
            if (accept)      last_cmd_q <= cmd;
            for (int b = 0; b < 8; b++) begin
                if (rcd_q[b] != '0) rcd_q[b] <= rcd_q[b] - RCD_W'(1);
            end
            if (accept && cmd == CMD_ACT) rcd_q[BA] <= RCD_LOAD;
            if (accept && is_rw) begin
                burst_active_q <= 1'b1;
                bst_wr_q       <= (cmd == CMD_WR);
                bst_ap_q       <= Addr[10];
                cyc_q          <= 8'd1;
            end else if (burst_active_q) begin
                cyc_q <= cyc_q + 8'd1;
                if (burst_done) burst_active_q <= 1'b0;
            end
            dq_oe_q <= in_beat && !bst_wr_q;
        end
    end

    // Storage and burst address latches carry no reset; contents survive RESET_n.
    always_ff @(posedge CLK) begin
        if (accept && cmd == CMD_ACT) row_q[BA] <= Addr[ROW_IDX_BITS-1:0];
        if (accept && is_rw) begin
            bst_ba_q  <= BA;
            bst_row_q <= row_q[BA];
            bst_col_q <= Addr[COL_IDX_BITS-1:0];
        end
        if (in_beat && !bst_wr_q) dq_out_q <= mem[beat_idx];
        if (in_beat && bst_wr_q) begin
            if (!LDM) mem[beat_idx][7:0]  <= DQ[7:0];
            if (!UDM) mem[beat_idx][15:8] <= DQ[15:8];
        end
    end

    assign DQ           = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign DQS_rd       = dq_oe_q;
    assign bank_open    = bank_open_q;
    assign last_cmd     = last_cmd_q;
    assign burst_active = burst_active_q;
    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder: read beats are queued when RD is issued
// and checked for cycle and data by a monitor as DQS_rd shows them.
module tb_ddr3_cmd_responder;

    localparam int CL  = 5;
    localparam int CWL = 5;
    localparam int BL  = 4;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b1;
    logic        CKE = 1'b1;
    logic        CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
    logic [2:0]  BA = 3'd0;
    logic [14:0] Addr = 15'd0;
    logic        LDM = 1'b0, UDM = 1'b0;
    wire  [15:0] DQ;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = 16'h0000;
    logic        DQS_rd;
    logic [7:0]  bank_open;
    logic [2:0]  last_cmd;
    logic        burst_active;
    logic        err_valid;
    logic [2:0]  err_code;

    assign DQ = tb_oe ? tb_dq : 16'hzzzz;

    ddr3_cmd_responder #(.CL(CL), .CWL(CWL), .BURST_LEN(BL), .T_RCD(3),
                         .ROW_IDX_BITS(2), .COL_IDX_BITS(5)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .CKE(CKE), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
        .BA(BA), .Addr(Addr), .LDM(LDM), .UDM(UDM), .DQ(DQ), .DQS_rd(DQS_rd),
        .bank_open(bank_open), .last_cmd(last_cmd), .burst_active(burst_active),
        .err_valid(err_valid), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int          c;
        logic [15:0] d;
    } beat_t;
    beat_t exp_q[$];

    int checks  = 0;
    int errors  = 0;
    int dqs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Drive one command at a negedge; t is the rising edge that samples it.
    task automatic issue(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a,
                         output int t);
        {CS, RAS, CAS, WE} = c;
        BA   = ba;
        Addr = a;
        t    = cyc + 1;
        tick();
        {CS, RAS, CAS, WE} = C_NOP;
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        chk({tag, "_err_valid"}, err_valid, 1);
        chk({tag, "_err_code"}, err_code, code);
    endtask

    task automatic push_rd(input int t, input logic [63:0] dw);
        for (int k = 0; k < BL; k++)
            exp_q.push_back('{t + CL + k, dw[63 - 16*k -: 16]});
    endtask

    task automatic write_burst(input int t, input logic [63:0] dw, input logic [3:0] udm);
        while (cyc < t + CWL - 1) tick();
        for (int k = 0; k < BL; k++) begin
            tb_oe = 1'b1;
            tb_dq = dw[63 - 16*k -: 16];
            UDM   = udm[k];
            tick();
        end
        tb_oe = 1'b0;
        UDM   = 1'b0;
    endtask

    always @(negedge CLK) begin
        beat_t e;
        if (DQS_rd) begin
            dqs_cnt++;
            chk("rd_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_cycle", cyc, e.c);
                chk("rd_data", DQ, e.d);
            end
        end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
            chk("rd_missing_beat", DQS_rd, 1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, d0;
        #1 RESET_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_bank_open", bank_open, 0);
        chk("rst_last_cmd", last_cmd, 0);
        chk("rst_burst_active", burst_active, 0);
        chk("rst_dqs", DQS_rd, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        RESET_n = 1'b1;
        tick();

        // Open bank 3 row 5, write col 6 exactly T_RCD later
        issue(C_ACT, 3'd3, 15'd5, t);
        chk("act_last_cmd", last_cmd, 1);
        chk("act_bank_open", bank_open, 8'h08);
        chk("act_no_err", err_valid, 0);
        tick();
        tick();
        issue(C_WR, 3'd3, 15'd6, t);
        chk("wr_no_err", err_valid, 0);
        chk("wr_busy", burst_active, 1);
        chk("wr_last_cmd", last_cmd, 3);
        write_burst(t, 64'hA5A5_1111_2222_3333, 4'b0000);
        chk("wr_busy_last_beat", burst_active, 1);
        tick();
        chk("wr_idle", burst_active, 0);

        d0 = dqs_cnt;
        issue(C_RD, 3'd3, 15'd6, t);
        push_rd(t, 64'hA5A5_1111_2222_3333);
        repeat (CL + BL) tick();
        chk("rd_dqs_count", dqs_cnt - d0, 4);
        chk("rd_queue_drained", exp_q.size(), 0);
        chk("rd_idle", burst_active, 0);

        // Upper byte masked on beat 1
        issue(C_WR, 3'd3, 15'd6, t);
        write_burst(t, 64'hA5A5_FFFF_2222_3333, 4'b0010);
        tick();
        issue(C_RD, 3'd3, 15'd6, t);
        push_rd(t, 64'hA5A5_11FF_2222_3333);
        repeat (CL + BL) tick();

        // Read to a closed bank
        d0 = dqs_cnt;
        issue(C_RD, 3'd2, 15'd0, t);
        expect_err("rd_closed", 3'd1);
        chk("rd_closed_idle", burst_active, 0);
        tick();
        chk("err_pulse_one_cycle", err_valid, 0);
        chk("err_code_held", err_code, 1);
        repeat (CL + BL) tick();
        chk("rd_closed_no_dqs", dqs_cnt - d0, 0);

        issue(C_ACT, 3'd1, 15'd2, t);
        issue(C_RD, 3'd1, 15'd0, t);
        expect_err("rd_trcd", 3'd3);
        issue(C_ACT, 3'd3, 15'd5, t);
        expect_err("act_open_bank", 3'd2);

        // Start at col 4: wraps 4,5,6,7
        issue(C_RD, 3'd3, 15'd4, t);
        chk("rd4_no_err", err_valid, 0);
        push_rd(t, 64'h2222_3333_A5A5_11FF);
        issue(C_RD, 3'd3, 15'd6, t2);
        expect_err("rd_busy", 3'd4);
        issue(C_RD, 3'd2, 15'd0, t2);
        expect_err("rd_prio_closed_over_busy", 3'd1);
        repeat (CL + BL) tick();
        chk("rd4_idle", burst_active, 0);

        // Auto-precharge; ACT on the auto-close edge still sees the bank open
        issue(C_RD, 3'd3, 15'h0406, t);
        push_rd(t, 64'hA5A5_11FF_2222_3333);
        while (cyc < t + CL + BL - 1) tick();
        chk("ap_open_at_last_beat", bank_open[3], 1);
        issue(C_ACT, 3'd3, 15'd5, t2);
        expect_err("act_on_autoclose", 3'd2);
        chk("ap_closed", bank_open, 8'h02);

        issue(C_REF, 3'd0, 15'd0, t);
        expect_err("ref_bank_open", 3'd6);
        issue(C_PRE, 3'd0, 15'h0400, t);
        chk("pre_all_closed", bank_open, 0);
        chk("pre_last_cmd", last_cmd, 4);
        chk("pre_no_err", err_valid, 0);
        issue(C_REF, 3'd0, 15'd0, t);
        chk("ref_last_cmd", last_cmd, 5);
        chk("ref_no_err", err_valid, 0);

        CKE = 1'b0;
        issue(C_MRS, 3'd0, 15'd0, t);
        expect_err("cke_low_cmd", 3'd5);
        chk("cke_last_cmd_kept", last_cmd, 5);
        issue(C_NOP, 3'd0, 15'd0, t);
        chk("cke_low_nop_ok", err_valid, 0);
        CKE = 1'b1;

        // Reset in the middle of a read burst
        issue(C_ACT, 3'd3, 15'd5, t);
        tick();
        tick();
        issue(C_RD, 3'd3, 15'd6, t);
        push_rd(t, 64'hA5A5_11FF_2222_3333);
        while (cyc < t + CL + 1) tick();
        chk("mid_read_dqs", DQS_rd, 1);
        #2 RESET_n = 1'b0;
        #1;
        chk("mid_rst_dqs", DQS_rd, 0);
        chk("mid_rst_busy", burst_active, 0);
        chk("mid_rst_bank_open", bank_open, 0);
        chk("mid_rst_err_code", err_code, 0);
        exp_q.delete();
        d0 = dqs_cnt;
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (CL + BL) tick();
        chk("post_rst_no_dqs", dqs_cnt - d0, 0);
        chk("post_rst_last_cmd", last_cmd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
